// File: rtl/mem_port_arbiter.sv
// Two-port memory arbiter: serialises CPU (port C) and DMA (port D) accesses
// onto one 15-bit address / 32-bit data memory port. Ties go to the CPU or
// alternate round-robin. A wait-state counter aborts accesses whose ready
// never arrives.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | no access in flight; arbitrate c_req/d_req
// S_ISSUE | one-cycle mem_start (read) or mem_w (write) strobe
// S_WAIT  | wait for the ready matching the operation, or time out
// S_DONE  | one-cycle done pulse to the owner (plus bus_err on abort)
module mem_port_arbiter #(
  parameter int unsigned TIMEOUT  = 255,
  parameter bit          CPU_PRIO = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        c_req,
  input  logic        c_w,
  input  logic [14:0] c_addr,
  input  logic [31:0] c_wdata,
  output logic [31:0] c_rdata,
  output logic        c_done,
  input  logic        d_req,
  input  logic        d_w,
  input  logic [14:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_done,
  output logic [14:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_w,
  output logic        mem_start,
  input  logic [31:0] mem_rdata,
  input  logic        mem_readrdy,
  input  logic        mem_saverdy,
  output logic        owner,
  output logic        busy,
  output logic        bus_err
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  // Abort fires in the WAIT cycle where the count reaches TIMEOUT, i.e. after
  // TIMEOUT wait cycles without the expected ready.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        w_q, w_d;
  logic        owner_q, owner_d;
  logic [14:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        mem_w_q, mem_w_d;
  logic        mem_start_q, mem_start_d;
  logic [31:0] c_rdata_q, c_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic        c_done_q, c_done_d;
  logic        d_done_q, d_done_d;
  logic        busy_q, busy_d;
  logic        bus_err_q, bus_err_d;
  logic        grant;
  logic        rdy;

  // Next-state and registered-output computation for the arbiter FSM.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    w_d         = w_q;
    owner_d     = owner_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_w_d     = 1'b0;
    mem_start_d = 1'b0;
    c_rdata_d   = c_rdata_q;
    d_rdata_d   = d_rdata_q;
    c_done_d    = 1'b0;
    d_done_d    = 1'b0;
    bus_err_d   = 1'b0;
    grant       = 1'b0;
    rdy         = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (c_req || d_req) begin
          if (c_req && d_req) grant = CPU_PRIO ? 1'b0 : ~owner_q;
          else                grant = d_req;
          owner_d     = grant;
          w_d         = grant ? d_w : c_w;
          mem_addr_d  = grant ? d_addr : c_addr;
          mem_wdata_d = grant ? d_wdata : c_wdata;
          mem_w_d     = w_d;
          mem_start_d = ~w_d;
          state_d     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = 8'd0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        rdy = w_q ? mem_saverdy : mem_readrdy;
        if (rdy) begin
          if (!w_q) begin
            if (owner_q) d_rdata_d = mem_rdata;
            else         c_rdata_d = mem_rdata;
          end
          c_done_d = ~owner_q;
          d_done_d = owner_q;
          state_d  = S_DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == CNT_LAST) begin
            if (owner_q) d_rdata_d = 32'd0;
            else         c_rdata_d = 32'd0;
            c_done_d  = ~owner_q;
            d_done_d  = owner_q;
            bus_err_d = 1'b1;
            state_d   = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers; reset drops any in-flight access silently.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= 8'd0;
      w_q         <= 1'b0;
      owner_q     <= 1'b1;
      mem_addr_q  <= 15'd0;
      mem_wdata_q <= 32'd0;
      mem_w_q     <= 1'b0;
      mem_start_q <= 1'b0;
      c_rdata_q   <= 32'd0;
      d_rdata_q   <= 32'd0;
      c_done_q    <= 1'b0;
      d_done_q    <= 1'b0;
      busy_q      <= 1'b0;
      bus_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      w_q         <= w_d;
      owner_q     <= owner_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_w_q     <= mem_w_d;
      mem_start_q <= mem_start_d;
      c_rdata_q   <= c_rdata_d;
      d_rdata_q   <= d_rdata_d;
      c_done_q    <= c_done_d;
      d_done_q    <= d_done_d;
      busy_q      <= busy_d;
      bus_err_q   <= bus_err_d;
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_w     = mem_w_q;
  assign mem_start = mem_start_q;
  assign c_rdata   = c_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign c_done    = c_done_q;
  assign d_done    = d_done_q;
  assign owner     = owner_q;
  assign busy      = busy_q;
  assign bus_err   = bus_err_q;

endmodule
